// File: rtl/m_btn_reader_pkg.sv
// Shared definitions for the push-button reader: FSM encodings, board-clock
// default timing constants and a counter-width helper.
package m_btn_reader_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE         = 2'd0,
    BTN_PRESS_WAIT   = 2'd1,
    BTN_HELD         = 2'd2,
    BTN_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 10 ms debounce and 1 s long-press at the 100 MHz clk_wiz output.
  localparam int BTN_DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int BTN_LONG_CYCLES_DEF     = 100000000;

  // Width able to hold 0..n, never less than one bit.
  function automatic int btn_cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/m_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module m_sync2 (
  input  logic w_clk,
  input  logic w_rst_n,
  input  logic w_d,
  output logic w_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= w_d;
      sync_q <= meta_q;
    end
  end

  assign w_q = sync_q;

endmodule

// File: rtl/m_btn_reader.sv
// Push-button reader: synchronize, debounce, press/release pulses and a
// wrapping press counter. Long-press pulse enabled by BTN_LONGPRESS_EN.
module m_btn_reader
  import m_btn_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 8,
  parameter int LONG_CYCLES     = BTN_LONG_CYCLES_DEF
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             w_btn,
  output logic             w_level,
  output logic             w_press,
  output logic             w_release,
  output logic [CNT_W-1:0] w_count,
  output logic             w_long
);

  localparam int            CW      = btn_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
    $error("m_btn_reader: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  logic             s_btn;
  btn_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic [CNT_W-1:0] count_q;
  logic             press_accept;
  logic             release_accept;

  m_sync2 u_sync (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_d     (w_btn),
    .w_q     (s_btn)
  );

  assign press_accept   = (state_q == BTN_PRESS_WAIT)   &&  s_btn && (cnt_q == DB_LAST);
  assign release_accept = (state_q == BTN_RELEASE_WAIT) && !s_btn && (cnt_q == DB_LAST);

  // The stability counter only runs in the two WAIT states and is zeroed on
  // every transition, so IDLE and HELD always hold it at 0.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q   <= BTN_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        BTN_IDLE: begin
          if (s_btn) begin
            state_q <= BTN_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        BTN_PRESS_WAIT: begin
          if (!s_btn) begin
            state_q <= BTN_IDLE;
            cnt_q   <= '0;
          end else if (press_accept) begin
            state_q <= BTN_HELD;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
            count_q <= count_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BTN_HELD: begin
          if (!s_btn) begin
            state_q <= BTN_RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        BTN_RELEASE_WAIT: begin
          if (s_btn) begin
            state_q <= BTN_HELD;
            cnt_q   <= '0;
          end else if (release_accept) begin
            state_q   <= BTN_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= BTN_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam int            LW        = btn_cnt_w(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYCLES);

  logic [LW-1:0] long_cnt_q;
  logic          long_q;

  // Parking at LONG_SAT after firing keeps the pulse to one per hold; a
  // glitch back into HELD does not clear it, only a fresh accepted press does.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_accept) begin
        long_cnt_q <= '0;
      end else if (state_q == BTN_HELD) begin
        if (long_cnt_q == LONG_LAST) begin
          long_q     <= 1'b1;
          long_cnt_q <= LONG_SAT;
        end else if (long_cnt_q != LONG_SAT) begin
          long_cnt_q <= long_cnt_q + 1'b1;
        end
      end
    end
  end

  assign w_long = long_q;
`else
  assign w_long = 1'b0;
`endif

  assign w_level   = level_q;
  assign w_press   = press_q;
  assign w_release = release_q;
  assign w_count   = count_q;

endmodule

// File: tb/tb_m_btn_reader.sv
// Directed bench for m_btn_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, CNT_W=3.
module tb_m_btn_reader;
  import m_btn_reader_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       level;
  logic       press;
  logic       rel;
  logic [2:0] count;
  logic       long_p;

  int n_vec = 0;
  int n_err = 0;

  int press_seen = 0;
  int release_seen = 0;
  int long_seen = 0;
  int cyc = 0;
  int press_cyc = 0;
  int long_cyc = 0;
  logic prev_level = 1'b0;

  typedef struct {
    logic       btn;
    int         cycles;
    int         exp_press;
    int         exp_rel;
    logic       exp_level;
    logic [2:0] exp_count;
  } vec_t;

  vec_t tbl[24];

  m_btn_reader #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3),
    .LONG_CYCLES     (20)
  ) dut (
    .w_clk     (clk),
    .w_rst_n   (rst_n),
    .w_btn     (btn),
    .w_level   (level),
    .w_press   (press),
    .w_release (rel),
    .w_count   (count),
    .w_long    (long_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: samples 2 time units after each posedge.
  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    if (press === 1'b1) begin
      press_seen = press_seen + 1;
      press_cyc  = cyc;
      if (level !== 1'b1) begin
        n_err = n_err + 1;
        $display("FAIL press_level cyc=%0d level=%b required=1", cyc, level);
      end
    end
    if (rel === 1'b1) release_seen = release_seen + 1;
    if (long_p === 1'b1) begin
      long_seen = long_seen + 1;
      long_cyc  = cyc;
    end
    if (press === 1'b1 && rel === 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL pulse_exclusive cyc=%0d press=1 release=1 required not both", cyc);
    end
    if (level !== prev_level && press !== 1'b1 && rel !== 1'b1) begin
      n_err = n_err + 1;
      $display("FAIL level_without_pulse cyc=%0d level=%b prev=%b", cyc, level, prev_level);
    end
    prev_level = level;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic apply_range(input int lo, input int hi);
    int p0;
    int r0;
    for (int i = lo; i <= hi; i++) begin
      p0  = press_seen;
      r0  = release_seen;
      btn = tbl[i].btn;
      repeat (tbl[i].cycles) @(negedge clk);
      $display("vec %0d btn=%b cycles=%0d press=%0d release=%0d level=%b count=%0d",
               i, tbl[i].btn, tbl[i].cycles, press_seen - p0, release_seen - r0, level, count);
      chk($sformatf("v%0d_press", i), press_seen - p0, tbl[i].exp_press);
      chk($sformatf("v%0d_release", i), release_seen - r0, tbl[i].exp_rel);
      chk($sformatf("v%0d_level", i), 32'(level), 32'(tbl[i].exp_level));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
    end
  endtask

  initial begin
    int bad;
    int p0;
    int r0;
    int l0;

    // Part 1: bounce, then (after the latency sequence) glitch handling.
    tbl[0] = '{1'b1, 3,  0, 0, 1'b0, 3'd0};  // 3-cycle bounce high
    tbl[1] = '{1'b0, 10, 0, 0, 1'b0, 3'd0};
    tbl[2] = '{1'b1, 10, 1, 0, 1'b1, 3'd2};  // accepted press
    tbl[3] = '{1'b0, 2,  0, 0, 1'b1, 3'd2};  // 2-cycle low glitch
    tbl[4] = '{1'b1, 10, 0, 0, 1'b1, 3'd2};
    tbl[5] = '{1'b0, 10, 0, 1, 1'b0, 3'd2};  // clean release
    // Part 2: 9 press/release pairs from a freshly reset counter.
    for (int k = 0; k < 9; k++) begin
      tbl[6 + 2*k]     = '{1'b1, 10, 1, 0, 1'b1, 3'((k + 1) % 8)};
      tbl[6 + 2*k + 1] = '{1'b0, 10, 0, 1, 1'b0, 3'((k + 1) % 8)};
    end

    // Reset state.
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_state", 32'(dut.state_q), 32'(BTN_IDLE));
    chk("rst_sync", 32'({dut.u_sync.meta_q, dut.u_sync.sync_q}), 32'd0);
    chk("rst_outputs", 32'({level, press, rel, long_p, count}), 32'd0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({level, press, rel, long_p, count} !== 7'd0 || dut.state_q !== BTN_IDLE) bad++;
    end
    $display("reset quiet window: 50 cycles, %0d non-idle", bad);
    chk("rst_quiet_cycles", bad, 0);

    apply_range(0, 1);

    // Press latency: pulse visible only after the 7th posedge.
    btn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("lat_press_k%0d", k), 32'(press), 32'(k == 7));
      if (k == 7) begin
        chk("lat_press_level", 32'(level), 32'd1);
        chk("lat_press_count", 32'(count), 32'd1);
      end
    end
    $display("press latency sequence done: level=%b count=%0d", level, count);
    btn = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("lat_rel_k%0d", k), 32'(rel), 32'(k == 7));
      if (k == 7) chk("lat_rel_level", 32'(level), 32'd0);
    end
    $display("release latency sequence done: level=%b count=%0d", level, count);

    apply_range(2, 5);

    // Reset asserted in the middle of PRESS_WAIT.
    p0  = press_seen;
    btn = 1'b1;
    repeat (4) @(negedge clk);
    chk("midpw_state", 32'(dut.state_q), 32'(BTN_PRESS_WAIT));
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    $display("reset mid-PRESS_WAIT: presses=%0d count=%0d", press_seen - p0, count);
    chk("midpw_press", press_seen - p0, 0);
    chk("midpw_count", 32'(count), 32'd0);
    chk("midpw_level", 32'(level), 32'd0);

    apply_range(6, 23);

    // Long hold of 40 cycles.
    p0  = press_seen;
    r0  = release_seen;
    l0  = long_seen;
    btn = 1'b1;
    repeat (40) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    $display("long hold: presses=%0d longs=%0d releases=%0d count=%0d",
             press_seen - p0, long_seen - l0, release_seen - r0, count);
    chk("long_press", press_seen - p0, 1);
    chk("long_release", release_seen - r0, 1);
    chk("long_count", 32'(count), 32'd2);
`ifdef BTN_LONGPRESS_EN
    chk("long_pulses", long_seen - l0, 1);
    chk("long_delay", long_cyc - press_cyc, 20);
`else
    chk("long_pulses_total", long_seen, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
